// File: rtl/hsid_pkg.sv
// HSID-wide types and defaults used by the OBI arbiter.
package hsid_pkg;

  typedef enum logic {
    ARB_FREE = 1'b0,  // no forwarded request pending
    ARB_HOLD = 1'b1   // forwarded request waiting for gnt, owner locked
  } hsid_x_obi_arb_state_t;

  localparam int HSID_OBI_ARB_NUM_REQ         = 2;
  localparam int HSID_OBI_ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI request/response structures shared by the HSID memory readers and arbiter.
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions awaiting rvalid.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module hsid_x_obi_arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Entry storage written on push.
  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/hsid_x_obi_arb.sv
// Round-robin arbiter sharing one OBI manager port between NUM_REQ readers,
// with in-order response routing through an ID FIFO.
module hsid_x_obi_arb
  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int NUM_REQ         = HSID_OBI_ARB_NUM_REQ,
  parameter int MAX_OUTSTANDING = HSID_OBI_ARB_MAX_OUTSTANDING,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  obi_req_t                           s_obi_req [NUM_REQ],
  output obi_resp_t                          s_obi_rsp [NUM_REQ],
  output obi_req_t                           m_obi_req,
  input  obi_resp_t                          m_obi_rsp,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               busy,
  output logic                               rsp_err
);

  hsid_x_obi_arb_state_t state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  rsp_err_q;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  fwd_valid;
  logic [ID_WIDTH-1:0]   fwd_id;
  logic                  push;
  logic                  pop;

  logic [ID_WIDTH-1:0]                fifo_head;
  logic [$clog2(MAX_OUTSTANDING):0]   fifo_count;
  logic                               fifo_empty;
  logic                               fifo_full;

  // Round-robin scan: first requester with req set, starting at rr_ptr_q.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && s_obi_req[idx].req) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  // Select the forwarded requester, drive the manager port and route gnt/rvalid back.
  always_comb begin
    if (state_q == ARB_HOLD) begin
      fwd_valid = 1'b1;
      fwd_id    = owner_q;
    end else begin
      fwd_valid = win_found && !fifo_full;
      fwd_id    = win_id;
    end

    m_obi_req = fwd_valid ? s_obi_req[fwd_id] : '0;
    push      = fwd_valid && s_obi_req[fwd_id].req && m_obi_rsp.gnt;
    pop       = m_obi_rsp.rvalid && !fifo_empty;

    for (int i = 0; i < NUM_REQ; i++) begin
      s_obi_rsp[i] = '0;
      if (fwd_valid && (fwd_id == ID_WIDTH'(i))) begin
        s_obi_rsp[i].gnt = m_obi_rsp.gnt;
      end
      if (pop && (fifo_head == ID_WIDTH'(i))) begin
        s_obi_rsp[i].rvalid = 1'b1;
        s_obi_rsp[i].rdata  = m_obi_rsp.rdata;
      end
    end
  end

  // Next state: lock the owner while gnt is withheld, advance the pointer past each granted requester.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      state_d  = ARB_FREE;
      rr_ptr_d = (fwd_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : fwd_id + ID_WIDTH'(1);
    end else if ((state_q == ARB_FREE) && fwd_valid) begin
      state_d = ARB_HOLD;
      owner_d = fwd_id;
    end
  end

  // Arbiter state registers and the sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_FREE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (m_obi_rsp.rvalid && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  hsid_x_obi_arb_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fwd_id),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign outstanding = fifo_count;
  assign busy        = (fifo_count != '0) || (state_q == ARB_HOLD);
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_hsid_x_obi_arb.sv
// Self-checking bench for hsid_x_obi_arb: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_hsid_x_obi_arb;
  import hsid_x_obi_inf_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst;
  obi_req_t   s_req [N];
  obi_resp_t  s_rsp [N];
  obi_req_t   m_req;
  obi_resp_t  m_rsp;
  logic [2:0] outstanding;
  logic       busy;
  logic       rsp_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of granted IDs, round-robin start, lock flag, error flag.
  int          m_q[$];
  logic [31:0] addr_q[$];
  int          m_rr;
  bit          m_hold;
  int          m_owner;
  bit          m_err;
  int          g_port;
  logic [31:0] a [N];

  hsid_x_obi_arb #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_obi_req   (s_req),
    .s_obi_rsp   (s_rsp),
    .m_obi_req   (m_req),
    .m_obi_rsp   (m_rsp),
    .outstanding (outstanding),
    .busy        (busy),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who the arbiter should be presenting downstream this cycle.
  function automatic void model_fwd(output bit fwd, output int id);
    fwd = 1'b0;
    id  = 0;
    if (m_hold) begin
      fwd = 1'b1;
      id  = m_owner;
    end else if (m_q.size() < MAXO) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (!fwd && s_req[p].req) begin
          fwd = 1'b1;
          id  = p;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    bit        fwd;
    int        id;
    obi_req_t  e_req;
    obi_resp_t e_rsp;
    model_fwd(fwd, id);
    e_req = fwd ? s_req[id] : '0;
    check({tag, ".m_req"}, 128'(m_req), 128'(e_req));
    for (int p = 0; p < N; p++) begin
      e_rsp = '0;
      if (fwd && id == p) e_rsp.gnt = m_rsp.gnt;
      if (m_rsp.rvalid && m_q.size() > 0 && m_q[0] == p) begin
        e_rsp.rvalid = 1'b1;
        e_rsp.rdata  = m_rsp.rdata;
      end
      check($sformatf("%s.s_rsp%0d", tag, p), 128'(s_rsp[p]), 128'(e_rsp));
    end
    check({tag, ".outstanding"}, 128'(outstanding), 128'(m_q.size()));
    check({tag, ".busy"}, 128'(busy), 128'((m_q.size() != 0) || m_hold));
    check({tag, ".rsp_err"}, 128'(rsp_err), 128'(m_err));
  endtask

  task automatic model_reset();
    m_q.delete();
    addr_q.delete();
    m_rr    = 0;
    m_hold  = 1'b0;
    m_owner = 0;
    m_err   = 1'b0;
    g_port  = -1;
  endtask

  // Advance the model by one clock edge using the inputs that were sampled.
  task automatic model_update();
    bit fwd;
    int id;
    model_fwd(fwd, id);
    g_port = -1;
    if (rst) begin
      model_reset();
    end else begin
      if (m_rsp.rvalid) begin
        if (m_q.size() > 0) begin
          void'(m_q.pop_front());
          void'(addr_q.pop_front());
        end else begin
          m_err = 1'b1;
        end
      end
      if (fwd && s_req[id].req && m_rsp.gnt) begin
        m_q.push_back(id);
        addr_q.push_back(s_req[id].addr);
        m_rr   = (id + 1) % N;
        m_hold = 1'b0;
        g_port = id;
      end else if (fwd && !m_hold) begin
        m_hold  = 1'b1;
        m_owner = id;
      end
    end
  endtask

  // One clock cycle: check settled outputs, clock, update the model.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < N; p++) s_req[p] = '0;
    m_rsp = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    step("reset");
    rst = 1'b0;
  endtask

  function automatic obi_req_t rd_req(input logic [31:0] addr);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.be    = 4'hF;
    r.addr  = addr;
    return r;
  endfunction

  // Respond to the oldest outstanding read with a tag derived from its address.
  task automatic drive_rsp(input bit gnt, input bit want_rvalid);
    m_rsp.gnt    = gnt;
    m_rsp.rvalid = want_rvalid && (m_q.size() > 0);
    m_rsp.rdata  = m_rsp.rvalid ? (32'hD000_0000 | addr_q[0]) : 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset, then an orphan rvalid sets the sticky error.
    step("idle0");
    step("idle1");
    m_rsp.rvalid = 1'b1;
    m_rsp.rdata  = 32'h1234_5678;
    step("orphan");
    m_rsp = '0;
    #1 check("orphan_err_set", 128'(rsp_err), 128'(1));
    step("orphan_hold0");
    step("orphan_hold1");
    #1 check("orphan_err_sticky", 128'(rsp_err), 128'(1));

    // Both ports request every cycle, gnt always, rvalid one cycle later.
    reset_dut();
    a[0] = 32'h0;
    a[1] = 32'h100;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < N; p++) s_req[p] = rd_req(a[p]);
      drive_rsp(1'b1, 1'b1);
      #1 check($sformatf("alt_gnt%0d", k), 128'(s_rsp[k % 2].gnt), 128'(1));
      if (m_rsp.rvalid) begin
        check($sformatf("alt_rdata%0d", k), 128'(s_rsp[(k + 1) % 2].rdata[8]), 128'((k + 1) % 2));
      end
      step($sformatf("alt%0d", k));
      if (g_port >= 0) a[g_port] = a[g_port] + 32'h4;
    end

    // Port 0 held off for three cycles while port 1 also requests.
    reset_dut();
    s_req[0] = rd_req(32'h40);
    s_req[1] = rd_req(32'h200);
    for (int k = 0; k < 3; k++) begin
      drive_rsp(1'b0, 1'b0);
      #1 check($sformatf("hold_addr%0d", k), 128'(m_req.addr), 128'(32'h40));
      if (k > 0) check($sformatf("hold_busy%0d", k), 128'(busy), 128'(1));
      step($sformatf("hold%0d", k));
    end
    drive_rsp(1'b1, 1'b0);
    #1 check("hold_gnt0", 128'(s_rsp[0].gnt), 128'(1));
    check("hold_gnt1_blocked", 128'(s_rsp[1].gnt), 128'(0));
    step("hold_grant");
    s_req[0] = rd_req(32'h44);
    #1 check("hold_next_winner", 128'(s_rsp[1].gnt), 128'(1));
    check("hold_next_addr", 128'(m_req.addr), 128'(32'h200));
    step("hold_next");

    // Fill the outstanding budget, then free one slot.
    reset_dut();
    a[0] = 32'h0;
    a[1] = 32'h100;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < N; p++) s_req[p] = rd_req(a[p]);
      drive_rsp(1'b1, 1'b0);
      step($sformatf("fill%0d", k));
      if (g_port >= 0) a[g_port] = a[g_port] + 32'h4;
    end
    for (int p = 0; p < N; p++) s_req[p] = rd_req(a[p]);
    #1 check("full_outstanding", 128'(outstanding), 128'(4));
    check("full_no_req", 128'(m_req.req), 128'(0));
    step("full_stall");
    drive_rsp(1'b1, 1'b1);
    #1 check("full_rvalid_port0", 128'(s_rsp[0].rvalid), 128'(1));
    check("full_still_blocked", 128'(m_req.req), 128'(0));
    step("full_pop");
    drive_rsp(1'b0, 1'b0);
    #1 check("resume_outstanding", 128'(outstanding), 128'(3));
    check("resume_req", 128'(m_req.req), 128'(1));
    step("resume");

    // Simultaneous grant and rvalid at outstanding=2.
    reset_dut();
    for (int p = 0; p < N; p++) s_req[p] = rd_req(32'h500 + 32'(p) * 32'h100);
    drive_rsp(1'b1, 1'b0);
    step("sim_g0");
    drive_rsp(1'b1, 1'b0);
    step("sim_g1");
    drive_rsp(1'b1, 1'b1);
    #1 check("sim_pre_outstanding", 128'(outstanding), 128'(2));
    check("sim_oldest_port0", 128'(s_rsp[0].rvalid), 128'(1));
    check("sim_not_port1", 128'(s_rsp[1].rvalid), 128'(0));
    step("sim_both");
    drive_rsp(1'b0, 1'b0);
    #1 check("sim_post_outstanding", 128'(outstanding), 128'(2));
    step("sim_after");

    // Reset in the middle of HOLD with three outstanding.
    reset_dut();
    for (int p = 0; p < N; p++) s_req[p] = rd_req(32'h800 + 32'(p) * 32'h100);
    for (int k = 0; k < 3; k++) begin
      drive_rsp(1'b1, 1'b0);
      step($sformatf("mid_g%0d", k));
    end
    drive_rsp(1'b0, 1'b0);
    step("mid_enter_hold");
    #1 check("mid_outstanding", 128'(outstanding), 128'(3));
    check("mid_busy", 128'(busy), 128'(1));
    reset_dut();
    #1 check("mid_rst_outstanding", 128'(outstanding), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_req", 128'(m_req.req), 128'(0));
    step("mid_idle");
    m_rsp.rvalid = 1'b1;
    m_rsp.rdata  = 32'hBAD0_0000;
    step("mid_late_rsp");
    m_rsp = '0;
    #1 check("mid_late_err", 128'(rsp_err), 128'(1));
    for (int p = 0; p < N; p++) s_req[p] = rd_req(32'hC00 + 32'(p) * 32'h100);
    drive_rsp(1'b1, 1'b0);
    #1 check("mid_rr_restart", 128'(s_rsp[0].gnt), 128'(1));
    step("mid_first_grant");

    // Randomized traffic: requesters hold their request until granted.
    reset_dut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!s_req[p].req || g_port == p) begin
          if ($urandom_range(0, 1) == 1) begin
            s_req[p].req   = 1'b1;
            s_req[p].we    = 1'($urandom);
            s_req[p].be    = 4'($urandom);
            s_req[p].addr  = $urandom & 32'hFFFF_FFFC;
            s_req[p].wdata = $urandom;
          end else begin
            s_req[p] = '0;
          end
        end
      end
      m_rsp.gnt    = ($urandom_range(0, 2) != 0);
      m_rsp.rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rsp.rdata  = $urandom;
      step($sformatf("rnd%0d", cyc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
